mole_game_fsm: RTL
==================

Name: mole_game_fsm

Overview:
- Parametrised successor to the single-mole game controller.
- Runs an N-hole whack-a-mole session with up to MAX_ACTIVE moles visible at once, each with its own lifetime timer.
- Handles level progression, lives, pause, win and lose.
- Sits between mouse_monitor/random_generator (inputs) and display_manager/buzzer_controller (outputs); game time advances only on a tick enable.

Parameters:
- N_HOLES, 12, number of holes (2..16).
- MAX_ACTIVE, 3, maximum simultaneously raised moles (1..N_HOLES).
- LIVES, 5, starting lives (1..7).
- MAX_LEVEL, 6, last playable level; win when level exceeds it.
- LEVEL_STEP, 100, score per level: level-up when score >= LEVEL_STEP*level.
- BASE_LIFE, 40, base mole lifetime in ticks.
- LIFE_STEP, 5, lifetime reduction per level above 1.
- MIN_LIFE, 8, lifetime floor in ticks.
- SPAWN_GAP, 10, ticks between spawn attempts.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tick  in  1  game-time enable, one-cycle pulse
- rnd  in  16  free-running random number
- click_hole  in  N_HOLES  one-cycle click pulse per hole
- click_pause  in  1  pause-button click pulse
- click_any  in  1  any left click pulse
- mole_up  out  N_HOLES  raised-mole mask
- score  out  16  current score, saturating
- live  out  3  remaining lives
- level  out  4  current level
- is_start  out  1  session running (PLAY or PAUSE)
- is_pause  out  1  state == PAUSE
- is_win  out  1  state == WIN
- is_lose  out  1  state == LOSE
- hit_pulse  out  1  one-cycle pulse on any scoring hit
- miss_pulse  out  1  one-cycle pulse on any expiry

Behaviour:
- All outputs are registered. On reset (takes priority over everything):
  - state=IDLE, mole_up=0, score=0, live=LIVES, level=1, all timers=0, spawn counter=SPAWN_GAP, pulses=0.
- States are IDLE, PLAY, PAUSE, WIN, LOSE.
- IDLE: click_any -> PLAY next cycle. Score, lives and level stay at their reset values.
- PLAY:
  - click_pause -> PAUSE. click_pause takes precedence; hits and ticks in that cycle are ignored.
  - Hits are processed every clock, independent of tick. A hit is click_hole[i] & mole_up[i]:
    - clear mole i and its timer;
    - score += 10*level (one add per hit hole, summed), saturating at 16'hFFFF;
    - hit_pulse=1.
  - Clicks on lowered holes are ignored.
  - On tick, each raised mole's timer decrements. A timer at 0 on tick means expiry:
    - clear that mole;
    - live -= number of expiries, saturating at 0;
    - miss_pulse=1.
  - A mole hit in the same cycle as its expiry counts as a hit, not a miss.
  - Spawn on tick: the spawn counter decrements; at 0 it reloads SPAWN_GAP and, if popcount(mole_up) < MAX_ACTIVE, raises one mole.
    - Start index = rnd[7:0] % N_HOLES. If that hole is up, probe upward with wrap and take the first free hole.
    - Timer loads max(MIN_LIFE, BASE_LIFE + rnd[11:8] - (level-1)*LIFE_STEP). Timer width is 8 bits.
  - Level check uses the post-update score: if score_next >= LEVEL_STEP*level, level += 1 (at most one per cycle).
  - Next-state after the update: level_next > MAX_LEVEL -> WIN; otherwise live_next == 0 -> LOSE (win wins ties).
- PAUSE:
  - Everything is frozen; tick, hits and the spawn counter are ignored. mole_up is held.
  - click_pause -> PLAY.
- WIN/LOSE:
  - mole_up is cleared on entry.
  - click_any -> IDLE and reloads score, live, level, timers and spawn counter to their reset values.
- Pulses last exactly one cycle.

Optional Feature:
- Macro MOLE_GAME_COMBO_EN.
- Defined:
  - a 3-bit combo counter increments on each hit cycle, saturating at 4, and resets to 1 on any expiry;
  - points per hit = 10*level*combo (combo value before increment, min 1);
  - combo is exported as an extra 3-bit output, combo.
- Undefined: multiplier fixed at 1, no combo port.

Decomposition:
- Package mole_game_pkg holds:
  - the state enum (IDLE, PLAY, PAUSE, WIN, LOSE);
  - the score and timer widths;
  - the points-per-hit constant (10).
- Sub-module mole_slot, instantiated N_HOLES times via generate:
  - holds one 8-bit timer and its up flag;
  - inputs: load/value, tick, hit, clear;
  - outputs: up, expire.
- Popcount, probe and saturation arithmetic stay in the top.

Test Plan:
- Reset, then click_any -> state PLAY, live=5, level=1, score=0, mole_up=0.
- rnd[7:0]=3 with hole 3 up and hole 4 free, spawn tick -> mole_up bit 4 set; timer = max(8, 40+rnd[11:8]) at level 1.
- Hit on raised hole 4 at level 2 -> score +20, hit_pulse for 1 cycle; a click on lowered hole 5 -> no change.
- Two timers expiring on the same tick with live=1 -> live=0, state LOSE, mole_up=0; then click_any -> IDLE with live=5.
- click_pause during PLAY, 50 ticks -> mole_up, timers and score unchanged; click_pause again -> PLAY resumes and the timer counts down from its held value.
- Score 590 at level 6 plus a 60-point hit -> level 7 -> WIN. With MOLE_GAME_COMBO_EN, 3 consecutive hits at level 1 -> +10, +20, +30.

Source files
------------

// File: rtl/mole_game_pkg.sv
// Shared types and widths for the whack-a-mole game controller.
package mole_game_pkg;

   localparam int unsigned SCORE_W     = 16;
   localparam int unsigned TIMER_W     = 8;
   localparam int unsigned LIVE_W      = 3;
   localparam int unsigned LEVEL_W     = 4;
   localparam int unsigned COMBO_W     = 3;
   localparam int unsigned PTS_PER_HIT = 10;

   typedef enum logic [2:0] {
      IDLE,
      PLAY,
      PAUSE,
      WIN,
      LOSE
   } state_t;

endpackage

// File: rtl/mole_slot.sv
// One hole: an up flag plus its lifetime timer. A hit in the same cycle as
// expiry wins, so expire_c is suppressed while hit is asserted.
module mole_slot
   import mole_game_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic [TIMER_W-1:0] value,
   input  logic               tick,
   input  logic               hit,
   input  logic               clear,
   output logic               up,
   output logic               expire_c
);

   logic               up_q, up_d;
   logic [TIMER_W-1:0] timer_q, timer_d;

   assign up       = up_q;
   assign expire_c = up_q & tick & ~hit & (timer_q == '0);

   // Next slot state: clear/hit/expiry lower the mole, load raises it, tick counts down.
   always_comb begin
      up_d    = up_q;
      timer_d = timer_q;
      if (clear || (hit && up_q) || expire_c) begin
         up_d    = 1'b0;
         timer_d = '0;
      end else if (load) begin
         up_d    = 1'b1;
         timer_d = value;
      end else if (tick && up_q) begin
         timer_d = timer_q - TIMER_W'(1);
      end
   end

   // Slot registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         up_q    <= 1'b0;
         timer_q <= '0;
      end else begin
         up_q    <= up_d;
         timer_q <= timer_d;
      end
   end

endmodule

// File: rtl/mole_game_fsm.sv
// N-hole whack-a-mole session controller: spawning, hits, expiries, lives,
// levels, pause, win/lose. Optional MOLE_GAME_COMBO_EN adds a hit-streak
// multiplier and exports it on the combo port.
module mole_game_fsm
   import mole_game_pkg::*;
#(
   parameter int unsigned N_HOLES    = 12,
   parameter int unsigned MAX_ACTIVE = 3,
   parameter int unsigned LIVES      = 5,
   parameter int unsigned MAX_LEVEL  = 6,
   parameter int unsigned LEVEL_STEP = 100,
   parameter int unsigned BASE_LIFE  = 40,
   parameter int unsigned LIFE_STEP  = 5,
   parameter int unsigned MIN_LIFE   = 8,
   parameter int unsigned SPAWN_GAP  = 10
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               tick,
   input  logic [15:0]        rnd,
   input  logic [N_HOLES-1:0] click_hole,
   input  logic               click_pause,
   input  logic               click_any,
   output logic [N_HOLES-1:0] mole_up,
   output logic [SCORE_W-1:0] score,
   output logic [LIVE_W-1:0]  live,
   output logic [LEVEL_W-1:0] level,
   output logic               is_start,
   output logic               is_pause,
   output logic               is_win,
   output logic               is_lose,
   output logic               hit_pulse,
   output logic               miss_pulse
`ifdef MOLE_GAME_COMBO_EN
   ,output logic [COMBO_W-1:0] combo
`endif
);

   localparam int unsigned IDX_W   = $clog2(N_HOLES);
   localparam int unsigned CNT_W   = IDX_W + 1;
   localparam int unsigned SPAWN_W = $clog2(SPAWN_GAP + 1);
   localparam int unsigned ARITH_W = 24;

   state_t               state_q, state_d;
   logic [SCORE_W-1:0]   score_q, score_d;
   logic [LIVE_W-1:0]    live_q, live_d;
   logic [LEVEL_W-1:0]   level_q, level_d;
   logic [SPAWN_W-1:0]   spawn_cnt_q, spawn_cnt_d;
   logic                 hit_q, hit_d, miss_q, miss_d;
   logic                 start_q, start_d, pause_q, pause_d;
   logic                 win_q, win_d, lose_q, lose_d;
   logic [COMBO_W-1:0]   combo_q, combo_d, mult_c;

   logic [N_HOLES-1:0]   up_vec, exp_vec, hit_vec, load_vec;
   logic                 play_active, tick_play, clear_all, spawn_due, do_spawn;
   logic [CNT_W-1:0]     n_up, n_hit, n_exp, probe;
   logic [IDX_W-1:0]     start_idx, spawn_idx;
   logic                 spawn_found;
   logic [TIMER_W-1:0]   life_val;
   logic [ARITH_W-1:0]   base_sum, life_dec, pts_c, sum_c;
   logic                 unused_rnd;

   assign unused_rnd  = ^rnd[15:12];
   assign play_active = (state_q == PLAY) & ~click_pause;
   assign tick_play   = tick & play_active;
   assign hit_vec     = click_hole & up_vec & {N_HOLES{play_active}};
   assign spawn_due   = tick_play & (spawn_cnt_q == SPAWN_W'(1));
   assign do_spawn    = spawn_due & (n_up < CNT_W'(MAX_ACTIVE)) & spawn_found;

`ifdef MOLE_GAME_COMBO_EN
   assign mult_c = (combo_q == '0) ? COMBO_W'(1) : combo_q;
   assign combo  = combo_q;
`else
   assign mult_c = COMBO_W'(1);
`endif

   for (genvar g = 0; g < N_HOLES; g++) begin : g_slot
      mole_slot u_slot (
         .clk      (clk),
         .reset    (reset),
         .load     (load_vec[g]),
         .value    (life_val),
         .tick     (tick_play),
         .hit      (hit_vec[g]),
         .clear    (clear_all),
         .up       (up_vec[g]),
         .expire_c (exp_vec[g])
      );
   end

   // Population counts, free-hole probe from the random start, and spawn lifetime.
   always_comb begin
      n_up        = '0;
      n_hit       = '0;
      n_exp       = '0;
      probe       = '0;
      spawn_found = 1'b0;
      spawn_idx   = '0;
      start_idx   = IDX_W'(rnd[7:0] % 8'(N_HOLES));
      for (int i = 0; i < N_HOLES; i++) begin
         n_up  = n_up  + CNT_W'(up_vec[i]);
         n_hit = n_hit + CNT_W'(hit_vec[i]);
         n_exp = n_exp + CNT_W'(exp_vec[i]);
      end
      for (int k = 0; k < N_HOLES; k++) begin
         probe = CNT_W'(start_idx) + CNT_W'(k);
         if (probe >= CNT_W'(N_HOLES)) probe = probe - CNT_W'(N_HOLES);
         if (!spawn_found && !up_vec[probe[IDX_W-1:0]]) begin
            spawn_found = 1'b1;
            spawn_idx   = probe[IDX_W-1:0];
         end
      end
      base_sum = ARITH_W'(BASE_LIFE) + ARITH_W'(rnd[11:8]);
      life_dec = ARITH_W'(level_q - LEVEL_W'(1)) * ARITH_W'(LIFE_STEP);
      if (base_sum < life_dec + ARITH_W'(MIN_LIFE)) life_val = TIMER_W'(MIN_LIFE);
      else                                          life_val = TIMER_W'(base_sum - life_dec);
   end

   // Next-state and session bookkeeping.
   always_comb begin
      state_d     = state_q;
      score_d     = score_q;
      live_d      = live_q;
      level_d     = level_q;
      spawn_cnt_d = spawn_cnt_q;
      combo_d     = combo_q;
      hit_d       = 1'b0;
      miss_d      = 1'b0;
      load_vec    = '0;
      pts_c       = '0;
      sum_c       = '0;
      unique case (state_q)
         IDLE: if (click_any) state_d = PLAY;
         PLAY: begin
            if (click_pause) begin
               state_d = PAUSE;
            end else begin
               hit_d  = |hit_vec;
               miss_d = |exp_vec;
               pts_c  = ARITH_W'(PTS_PER_HIT) * ARITH_W'(level_q) * ARITH_W'(mult_c) * ARITH_W'(n_hit);
               sum_c  = ARITH_W'(score_q) + pts_c;
               score_d = (sum_c > ARITH_W'(16'hFFFF)) ? '1 : SCORE_W'(sum_c);
               if (ARITH_W'(n_exp) >= ARITH_W'(live_q)) live_d = '0;
               else                                     live_d = live_q - LIVE_W'(n_exp);
               if (ARITH_W'(score_d) >= ARITH_W'(LEVEL_STEP) * ARITH_W'(level_q))
                  level_d = level_q + LEVEL_W'(1);
               if (tick_play)
                  spawn_cnt_d = spawn_due ? SPAWN_W'(SPAWN_GAP) : spawn_cnt_q - SPAWN_W'(1);
               if (do_spawn) load_vec[spawn_idx] = 1'b1;
               if (|exp_vec)                                  combo_d = COMBO_W'(1);
               else if (|hit_vec && combo_q < COMBO_W'(4))    combo_d = combo_q + COMBO_W'(1);
               if (ARITH_W'(level_d) > ARITH_W'(MAX_LEVEL)) state_d = WIN;
               else if (live_d == '0)                       state_d = LOSE;
            end
         end
         PAUSE: if (click_pause) state_d = PLAY;
         WIN, LOSE: begin
            if (click_any) begin
               state_d     = IDLE;
               score_d     = '0;
               live_d      = LIVE_W'(LIVES);
               level_d     = LEVEL_W'(1);
               spawn_cnt_d = SPAWN_W'(SPAWN_GAP);
               combo_d     = COMBO_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      clear_all = (state_d == WIN) || (state_d == LOSE);
      start_d   = (state_d == PLAY) || (state_d == PAUSE);
      pause_d   = (state_d == PAUSE);
      win_d     = (state_d == WIN);
      lose_d    = (state_d == LOSE);
   end

   // Session registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         score_q     <= '0;
         live_q      <= LIVE_W'(LIVES);
         level_q     <= LEVEL_W'(1);
         spawn_cnt_q <= SPAWN_W'(SPAWN_GAP);
         combo_q     <= COMBO_W'(1);
         hit_q       <= 1'b0;
         miss_q      <= 1'b0;
         start_q     <= 1'b0;
         pause_q     <= 1'b0;
         win_q       <= 1'b0;
         lose_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         score_q     <= score_d;
         live_q      <= live_d;
         level_q     <= level_d;
         spawn_cnt_q <= spawn_cnt_d;
         combo_q     <= combo_d;
         hit_q       <= hit_d;
         miss_q      <= miss_d;
         start_q     <= start_d;
         pause_q     <= pause_d;
         win_q       <= win_d;
         lose_q      <= lose_d;
      end
   end

   assign mole_up    = up_vec;
   assign score      = score_q;
   assign live       = live_q;
   assign level      = level_q;
   assign is_start   = start_q;
   assign is_pause   = pause_q;
   assign is_win     = win_q;
   assign is_lose    = lose_q;
   assign hit_pulse  = hit_q;
   assign miss_pulse = miss_q;

endmodule
